// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the ROM port arbiter.
package rom_arb_pkg;

    localparam int          ARB_ADDR_W = 12;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    typedef struct packed {
        logic                  req;
        logic [ARB_ADDR_W-1:0] addr;
    } rom_req_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_DM   = 2'd2
    } rom_gnt_e;

endpackage

// File: rtl/rom_port_arbiter.sv
// Shares one combinational ROM between the fetch port and the data load port,
// with registered responses, fill-word substitution and an anti-starvation counter for DM.
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int          ADDR_W    = 12,
    parameter int          DEPTH     = 128,
    parameter int          MAX_WAIT  = 4,
    parameter logic [31:0] FILL_WORD = NOP_INSTR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [31:0]       if_rdata_o,
    input  logic              dm_req_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    output logic              dm_gnt_o,
    output logic              dm_rvalid_o,
    output logic [31:0]       dm_rdata_o,
    output logic              dm_err_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [31:0]       rom_inst_i
);

    localparam int              WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    rom_gnt_e          gnt_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              if_oor_s, dm_oor_s, dm_bad_s;
    logic              if_pend_q, dm_pend_q, dm_err_q;
    logic [31:0]       if_rdata_q, dm_rdata_q;

    assign if_oor_s = int'(if_addr_i[ADDR_W-1:2]) >= DEPTH;
    assign dm_oor_s = int'(dm_addr_i[ADDR_W-1:2]) >= DEPTH;
    assign dm_bad_s = dm_oor_s || (dm_addr_i[1:0] != 2'b00);

    // Grant selection, winner address mux and DM aging counter next state.
    always_comb begin
        gnt_s      = GNT_NONE;
        win_addr_s = {ADDR_W{1'b0}};
        wait_d     = wait_q;
        if (reset) begin
            gnt_s = GNT_NONE;
        end else if (if_req_i && dm_req_i) begin
            if (wait_q == WAIT_MAX) begin
                gnt_s = GNT_DM;
            end else begin
                gnt_s = GNT_IF;
            end
        end else if (if_req_i) begin
            gnt_s = GNT_IF;
        end else if (dm_req_i) begin
            gnt_s = GNT_DM;
        end else begin
            gnt_s = GNT_NONE;
        end
        case (gnt_s)
            GNT_IF:  win_addr_s = if_addr_i;
            GNT_DM:  win_addr_s = dm_addr_i;
            default: win_addr_s = {ADDR_W{1'b0}};
        endcase
        if (!dm_req_i || gnt_s == GNT_DM) begin
            wait_d = {WAIT_W{1'b0}};
        end else if (wait_q != WAIT_MAX) begin
            wait_d = wait_q + WAIT_W'(1);
        end else begin
            wait_d = wait_q;
        end
    end

    // Fetch response register; a flush in the grant cycle kills the pending response.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_pend_q  <= 1'b0;
            if_rdata_q <= 32'h0000_0000;
        end else begin
            if_pend_q <= (gnt_s == GNT_IF) && !if_flush_i;
            if ((gnt_s == GNT_IF) && !if_flush_i) begin
                if_rdata_q <= if_oor_s ? FILL_WORD : rom_inst_i;
            end
        end
    end

    // Data response register plus aging counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            dm_pend_q  <= 1'b0;
            dm_err_q   <= 1'b0;
            dm_rdata_q <= 32'h0000_0000;
            wait_q     <= {WAIT_W{1'b0}};
        end else begin
            wait_q    <= wait_d;
            dm_pend_q <= (gnt_s == GNT_DM);
            dm_err_q  <= (gnt_s == GNT_DM) && dm_bad_s;
            if (gnt_s == GNT_DM) begin
                dm_rdata_q <= dm_bad_s ? FILL_WORD : rom_inst_i;
            end
        end
    end

    // Sync reset only takes effect at the edge, so responses are masked during the reset cycle.
    assign if_gnt_o    = (gnt_s == GNT_IF);
    assign dm_gnt_o    = (gnt_s == GNT_DM);
    assign rom_addr_o  = {win_addr_s[ADDR_W-1:2], 2'b00};
    assign if_rvalid_o = if_pend_q && !if_flush_i && !reset;
    assign if_rdata_o  = reset ? 32'h0000_0000 : if_rdata_q;
    assign dm_rvalid_o = dm_pend_q && !reset;
    assign dm_err_o    = dm_err_q && !reset;
    assign dm_rdata_o  = reset ? 32'h0000_0000 : dm_rdata_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Scoreboard bench: stimulus pushes expected grants/responses, a negedge monitor pops and compares.
module tb_rom_port_arbiter;

    localparam int          ADDR_W   = 12;
    localparam int          DEPTH    = 128;
    localparam int          MAX_WAIT = 4;
    localparam logic [31:0] FILL     = 32'h0000_0013;

    typedef struct {
        int              cyc;
        logic            ig;
        logic            dg;
        logic [ADDR_W-1:0] ra;
    } gexp_t;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } resp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              if_req = 1'b0, if_flush = 1'b0, dm_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = 12'h000, dm_addr = 12'h000;
    logic              if_gnt, if_rvalid, dm_gnt, dm_rvalid, dm_err;
    logic [31:0]       if_rdata, dm_rdata, rom_inst;
    logic [ADDR_W-1:0] rom_addr;

    logic [31:0] rom_mem [0:1023];
    assign rom_inst = rom_mem[rom_addr[ADDR_W-1:2]];

    rom_port_arbiter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .FILL_WORD(FILL)) dut (
        .clk(clk), .reset(reset),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
        .if_gnt_o(if_gnt), .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .dm_req_i(dm_req), .dm_addr_i(dm_addr),
        .dm_gnt_o(dm_gnt), .dm_rvalid_o(dm_rvalid), .dm_rdata_o(dm_rdata), .dm_err_o(dm_err),
        .rom_addr_o(rom_addr), .rom_inst_i(rom_inst)
    );

    always #5 clk = ~clk;

    int    cyc = 0;
    int    checks = 0;
    int    passes = 0;
    bit    started = 1'b0;
    int    m_dm_lost = 0;
    gexp_t gnt_q[$];
    resp_t if_q[$];
    resp_t dm_q[$];
    gexp_t ge;
    resp_t rr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    function automatic logic [31:0] rom_word(input logic [ADDR_W-1:0] a);
        int w;
        w = int'(a) / 4;
        return (w >= DEPTH) ? FILL : rom_mem[w];
    endfunction

    function automatic logic [ADDR_W-1:0] rand_addr(input bit for_dm);
        logic [ADDR_W-1:0] a;
        if ($urandom_range(0, 3) == 0) a = ADDR_W'($urandom_range(0, 4095));
        else a = ADDR_W'($urandom_range(0, 511));
        if (for_dm && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
        return a;
    endfunction

    // One bus cycle: drive inputs, predict grant from the arbitration rules, queue expected responses.
    task automatic cycle(input logic ir, input logic [ADDR_W-1:0] ia, input logic fl,
                         input logic dr, input logic [ADDR_W-1:0] da,
                         output logic ig, output logic dg);
        gexp_t g;
        resp_t r;
        int    widx;
        @(posedge clk);
        #1;
        reset = 1'b0; if_req = ir; if_addr = ia; if_flush = fl; dm_req = dr; dm_addr = da;
        ig = 1'b0; dg = 1'b0;
        if (ir && dr) begin
            if (m_dm_lost == MAX_WAIT) dg = 1'b1; else ig = 1'b1;
        end else if (ir) ig = 1'b1;
        else if (dr) dg = 1'b1;
        if (dr && !dg) m_dm_lost = (m_dm_lost < MAX_WAIT) ? m_dm_lost + 1 : MAX_WAIT;
        else m_dm_lost = 0;
        g.cyc = cyc; g.ig = ig; g.dg = dg;
        g.ra = ig ? (ia & 12'hFFC) : (dg ? (da & 12'hFFC) : 12'h000);
        gnt_q.push_back(g);
        if (ig && !fl) begin
            r.due = cyc + 1; r.data = rom_word(ia & 12'hFFC); r.err = 1'b0;
            if_q.push_back(r);
        end
        if (dg) begin
            widx = int'(da) / 4;
            r.due = cyc + 1;
            r.err = (da[1:0] != 2'b00) || (widx >= DEPTH);
            r.data = r.err ? FILL : rom_mem[widx];
            dm_q.push_back(r);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1; if_req = 1'b0; if_flush = 1'b0; dm_req = 1'b0;
        gnt_q.delete(); if_q.delete(); dm_q.delete();
        m_dm_lost = 0;
        started = 1'b1;
    endtask

    // Monitor: compares DUT outputs against the head of each expectation queue.
    always @(negedge clk) begin
        if (started) begin
            if (reset) begin
                check("rst_if_gnt", 32'(if_gnt), 32'd0);
                check("rst_dm_gnt", 32'(dm_gnt), 32'd0);
                check("rst_if_rvalid", 32'(if_rvalid), 32'd0);
                check("rst_dm_rvalid", 32'(dm_rvalid), 32'd0);
                check("rst_dm_err", 32'(dm_err), 32'd0);
                check("rst_if_rdata", if_rdata, 32'd0);
                check("rst_dm_rdata", dm_rdata, 32'd0);
                check("rst_rom_addr", 32'(rom_addr), 32'd0);
            end else begin
                if (gnt_q.size() > 0 && gnt_q[0].cyc == cyc) begin
                    ge = gnt_q.pop_front();
                    check("if_gnt", 32'(if_gnt), 32'(ge.ig));
                    check("dm_gnt", 32'(dm_gnt), 32'(ge.dg));
                    check("rom_addr", 32'(rom_addr), 32'(ge.ra));
                end
                if (if_q.size() > 0 && if_q[0].due == cyc) begin
                    rr = if_q.pop_front();
                    if (if_flush) begin
                        check("if_rvalid_flushed", 32'(if_rvalid), 32'd0);
                    end else begin
                        check("if_rvalid", 32'(if_rvalid), 32'd1);
                        check("if_rdata", if_rdata, rr.data);
                    end
                end else begin
                    check("if_rvalid_idle", 32'(if_rvalid), 32'd0);
                end
                if (dm_q.size() > 0 && dm_q[0].due == cyc) begin
                    rr = dm_q.pop_front();
                    check("dm_rvalid", 32'(dm_rvalid), 32'd1);
                    check("dm_rdata", dm_rdata, rr.data);
                    check("dm_err", 32'(dm_err), 32'(rr.err));
                end else begin
                    check("dm_rvalid_idle", 32'(dm_rvalid), 32'd0);
                    check("dm_err_idle", 32'(dm_err), 32'd0);
                end
            end
        end
    end

    initial begin
        logic              ig, dg, ir, dr, fl;
        logic [ADDR_W-1:0] ia, da;
        for (int i = 0; i < 1024; i++) rom_mem[i] = $urandom;

        do_reset();
        cycle(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, ig, dg);
        @(negedge clk);
        check("post_rst_if_rdata", if_rdata, 32'd0);
        check("post_rst_dm_rdata", dm_rdata, 32'd0);

        // Fetch-only consecutive words
        cycle(1'b1, 12'h004, 1'b0, 1'b0, 12'h000, ig, dg);
        cycle(1'b1, 12'h008, 1'b0, 1'b0, 12'h000, ig, dg);
        cycle(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, ig, dg);

        // Both ports held: DM forced through after MAX_WAIT losses, pattern repeats
        for (int k = 0; k < 12; k++) cycle(1'b1, 12'(32 + 4 * k), 1'b0, 1'b1, 12'h030, ig, dg);
        cycle(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, ig, dg);

        // DM out of range and misaligned
        cycle(1'b0, 12'h000, 1'b0, 1'b1, 12'h200, ig, dg);
        cycle(1'b0, 12'h000, 1'b0, 1'b1, 12'h006, ig, dg);
        cycle(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, ig, dg);

        // Flush in grant cycle, then flush only in response cycle
        cycle(1'b1, 12'h010, 1'b1, 1'b0, 12'h000, ig, dg);
        cycle(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, ig, dg);
        cycle(1'b1, 12'h014, 1'b0, 1'b0, 12'h000, ig, dg);
        cycle(1'b0, 12'h000, 1'b1, 1'b0, 12'h000, ig, dg);

        // Reset right after a DM grant, then a normal fetch
        cycle(1'b0, 12'h000, 1'b0, 1'b1, 12'h010, ig, dg);
        do_reset();
        cycle(1'b1, 12'h00C, 1'b0, 1'b0, 12'h000, ig, dg);
        cycle(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, ig, dg);

        // Misaligned fetch is treated as aligned
        cycle(1'b1, 12'h00A, 1'b0, 1'b0, 12'h000, ig, dg);
        cycle(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, ig, dg);

        // Randomized traffic with request hold-until-grant
        ir = 1'b0; dr = 1'b0; ia = 12'h000; da = 12'h000;
        for (int n = 0; n < 2000; n++) begin
            if (!ir && $urandom_range(0, 2) != 0) begin ir = 1'b1; ia = rand_addr(1'b0); end
            if (!dr && $urandom_range(0, 2) != 0) begin dr = 1'b1; da = rand_addr(1'b1); end
            fl = ($urandom_range(0, 7) == 0);
            cycle(ir, ia, fl, dr, da, ig, dg);
            if (ig) ir = 1'b0;
            if (dg) dr = 1'b0;
        end
        for (int n = 0; n < 3; n++) cycle(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, ig, dg);
        @(negedge clk);
        #1;
        check("gnt_q_drained", 32'(gnt_q.size()), 32'd0);
        check("if_q_drained", 32'(if_q.size()), 32'd0);
        check("dm_q_drained", 32'(dm_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
